instruction_decoder: RTL and testbench
======================================

Name: instruction_decoder

Overview:
Fetch/decode stage directly upstream of program_sequencer. Takes the instruction word currently addressed by pc and drives the sequencer's jump, conditional_jump, dont_jmp and jump_address inputs. Owns the ALU zero flag and a hardware loop counter that together resolve conditional branches. Also registers the instruction for the datapath.

Parameters:
LOOP_W, 4, width of loop counter; immediate of LDC is zero-extended into it
STARTUP_CYCLES, 1, cycles after reset release during which decode outputs stay inactive (range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
pm_data  input  8  instruction at current pc, valid in the same cycle
alu_zero  input  1  ALU result-is-zero
alu_flag_we  input  1  latch alu_zero into zero flag this cycle
jump  output  1  unconditional jump request to sequencer
conditional_jump  output  1  conditional jump request to sequencer
dont_jmp  output  1  condition false; sequencer ignores conditional_jump
jump_address  output  4  target page (sequencer forms {jump_address,4'h0})
ir  output  8  registered instruction for datapath
ir_valid  output  1  ir holds a real instruction
loop_count  output  LOOP_W  current loop counter
zero_flag  output  1  registered zero flag

Behaviour:
- Opcode = pm_data[7:4], operand = pm_data[3:0]. 0x0-0xB datapath ops (no flow effect); 0xC DJNZ a; 0xD LDC #n; 0xE JMP a; 0xF JNZ a.
- FSM states: FLUSH, RUN. Reset enters FLUSH, startup counter = 0. FLUSH increments each cycle; at STARTUP_CYCLES-1 goes to RUN on next edge. RUN holds until reset. Reset asserted mid-operation forces FLUSH immediately (async).
- In FLUSH: jump=0, conditional_jump=0, dont_jmp=1, jump_address=0, ir=8'h00, ir_valid=0; counters/flag frozen at reset values.
- Reset values: ir=8'h00, ir_valid=0, loop_count=0, zero_flag=0; all combinational outputs as in FLUSH.
- RUN, combinational (zero latency, same cycle as pm_data):
  - jump_address = operand for 0xC/0xE/0xF, else 0.
  - jump = 1 iff opcode 0xE.
  - conditional_jump = 1 iff opcode 0xC or 0xF.
  - dont_jmp: 0xF -> zero_flag; 0xC -> (loop_count <= 1); all others -> 1.
- RUN, registered (1-cycle latency): ir <= pm_data, ir_valid <= 1.
- Zero flag: on alu_flag_we, zero_flag <= alu_zero; else holds. Written even while decoding any opcode.
- Loop counter: LDC loads zero-extended operand (truncated to LOOP_W if LOOP_W<4). DJNZ with loop_count != 0 decrements by 1. DJNZ with loop_count == 0 holds 0 (no wrap) and does not jump. Other opcodes hold.
- DJNZ semantics: jump taken iff the post-decrement value is nonzero. loop_count=1 -> becomes 0, falls through.
- Back-to-back jumps: every cycle is decoded independently; no delay slot, no bubble.

Optional Feature:
ZERO_FLAG_BYPASS_EN
- Defined: JNZ uses alu_zero directly when alu_flag_we=1 in the same cycle (forwarding); otherwise it uses zero_flag.
- Undefined: JNZ always uses registered zero_flag (one-cycle-old value).

Decomposition:
- Shared package: opcode constants (OP_DJNZ=4'hC, OP_LDC=4'hD, OP_JMP=4'hE, OP_JNZ=4'hF), FSM state typedef {FLUSH, RUN}, NOP word 8'h00.
- One natural sub-module: loop_counter (load/decrement/saturate-at-0, LOOP_W wide), instantiated once.

Test Plan:
- Reset release, STARTUP_CYCLES=1, pm_data=8'hE5 -> cycle 0: jump=0, ir_valid=0; cycle 1: jump=1, jump_address=5; next edge ir=8'hE5, ir_valid=1.
- alu_zero=1 with alu_flag_we=1, then pm_data=8'hF3 -> conditional_jump=1, dont_jmp=1. Repeat with alu_zero=0 -> dont_jmp=0, jump_address=3.
- pm_data=8'hD3 then 8'hC2 three times -> loop_count 3,2,1,0; dont_jmp 0,0,1; at loop_count=0 a further DJNZ keeps it 0 with dont_jmp=1.
- With the bypass macro defined: same cycle alu_flag_we=1, alu_zero=0, flag previously 1, pm_data=8'hF7 -> dont_jmp=0. Without the macro -> dont_jmp=1.
- Assert reset_n=0 mid-loop (loop_count=2, ir=8'hC2) -> immediately ir=0, loop_count=0, jump=0, dont_jmp=1; after release, outputs stay inactive for STARTUP_CYCLES.
- Datapath op 8'h47 -> jump=0, conditional_jump=0, dont_jmp=1, jump_address=0; ir=8'h47 next cycle.

Source files
------------

// File: rtl/instruction_decoder_pkg.sv
// Shared opcodes, FSM state type and helpers for the instruction decoder.
package instruction_decoder_pkg;

    localparam logic [3:0] OP_DJNZ = 4'hC;
    localparam logic [3:0] OP_LDC  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_JNZ  = 4'hF;

    localparam logic [7:0] NOP_WORD = 8'h00;

    typedef enum logic {
        FLUSH,
        RUN
    } dec_state_e;

    function automatic logic [3:0] opcode_of(input logic [7:0] word);
        return word[7:4];
    endfunction

    function automatic logic [3:0] operand_of(input logic [7:0] word);
        return word[3:0];
    endfunction

    // Opcodes whose operand is a jump target page.
    function automatic logic is_flow_op(input logic [3:0] opcode);
        return (opcode == OP_DJNZ) || (opcode == OP_JMP) || (opcode == OP_JNZ);
    endfunction

endpackage

// File: rtl/instruction_decoder_loop_counter.sv
// Hardware loop counter: load from LDC immediate, decrement on DJNZ, saturate at zero.
module instruction_decoder_loop_counter #(
    parameter int unsigned LOOP_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              dec,
    input  logic [3:0]        load_value,
    output logic [LOOP_W-1:0] count,
    output logic              at_most_one
);

    logic [LOOP_W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (load) begin
            // Zero-extends or truncates the 4-bit immediate to LOOP_W.
            count_d = LOOP_W'(load_value);
        end else if (dec && (count != '0)) begin
            count_d = count - LOOP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    // A DJNZ falls through when the post-decrement value would be zero.
    assign at_most_one = (count <= LOOP_W'(1));

endmodule

// File: rtl/instruction_decoder.sv
// Fetch/decode stage feeding program_sequencer; optional ZERO_FLAG_BYPASS_EN forwards
// alu_zero to JNZ in the cycle it is written.
module instruction_decoder
    import instruction_decoder_pkg::*;
#(
    parameter int unsigned LOOP_W         = 4,
    parameter int unsigned STARTUP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        pm_data,
    input  logic              alu_zero,
    input  logic              alu_flag_we,
    output logic              jump,
    output logic              conditional_jump,
    output logic              dont_jmp,
    output logic [3:0]        jump_address,
    output logic [7:0]        ir,
    output logic              ir_valid,
    output logic [LOOP_W-1:0] loop_count,
    output logic              zero_flag
);

    dec_state_e state_q;
    logic [3:0] startup_q;
    logic       run;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       lc_at_most_one;
    logic       jnz_zero;

    assign run     = (state_q == RUN);
    assign opcode  = opcode_of(pm_data);
    assign operand = operand_of(pm_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FLUSH;
            startup_q <= '0;
            ir        <= NOP_WORD;
            ir_valid  <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            case (state_q)
                FLUSH: begin
                    startup_q <= startup_q + 4'd1;
                    if (startup_q == 4'(STARTUP_CYCLES - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    ir       <= pm_data;
                    ir_valid <= 1'b1;
                    if (alu_flag_we) begin
                        zero_flag <= alu_zero;
                    end
                end
                default: state_q <= FLUSH;
            endcase
        end
    end

    instruction_decoder_loop_counter #(
        .LOOP_W(LOOP_W)
    ) u_loop_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (run && (opcode == OP_LDC)),
        .dec        (run && (opcode == OP_DJNZ)),
        .load_value (operand),
        .count      (loop_count),
        .at_most_one(lc_at_most_one)
    );

`ifdef ZERO_FLAG_BYPASS_EN
    assign jnz_zero = alu_flag_we ? alu_zero : zero_flag;
`else
    assign jnz_zero = zero_flag;
`endif

    always_comb begin
        jump             = 1'b0;
        conditional_jump = 1'b0;
        dont_jmp         = 1'b1;
        jump_address     = 4'h0;
        if (run) begin
            if (is_flow_op(opcode)) begin
                jump_address = operand;
            end
            case (opcode)
                OP_JMP: jump = 1'b1;
                OP_DJNZ: begin
                    conditional_jump = 1'b1;
                    dont_jmp         = lc_at_most_one;
                end
                OP_JNZ: begin
                    conditional_jump = 1'b1;
                    dont_jmp         = jnz_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Table-driven self-checking bench for instruction_decoder (STARTUP_CYCLES=1, LOOP_W=4).
module tb_instruction_decoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       alu_flag_we;
    logic       jump;
    logic       conditional_jump;
    logic       dont_jmp;
    logic [3:0] jump_address;
    logic [7:0] ir;
    logic       ir_valid;
    logic [3:0] loop_count;
    logic       zero_flag;

    int total;
    int bad;

`ifdef ZERO_FLAG_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    instruction_decoder #(
        .LOOP_W        (4),
        .STARTUP_CYCLES(1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pm_data         (pm_data),
        .alu_zero        (alu_zero),
        .alu_flag_we     (alu_flag_we),
        .jump            (jump),
        .conditional_jump(conditional_jump),
        .dont_jmp        (dont_jmp),
        .jump_address    (jump_address),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .loop_count      (loop_count),
        .zero_flag       (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pm;
        logic       az;
        logic       we;
        logic       j;
        logic       cj;
        logic       dj;
        logic [3:0] ja;
        logic [3:0] lc;
        logic       zf;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_inactive(input string tag);
        check({tag, ".jump"}, 32'(jump), 32'd0);
        check({tag, ".cj"}, 32'(conditional_jump), 32'd0);
        check({tag, ".dont_jmp"}, 32'(dont_jmp), 32'd1);
        check({tag, ".jaddr"}, 32'(jump_address), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //           pm     az    we    j     cj    dj    ja    lc    zf
        vecs[0]  = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'd0, 1'b0};
        vecs[1]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'd0, 1'b1};
        vecs[2]  = '{8'hF3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'd0, 1'b1};
        vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'd0, 1'b0};
        vecs[4]  = '{8'hF3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'd0, 1'b0};
        vecs[5]  = '{8'hD3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 1'b0};
        vecs[6]  = '{8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'd2, 1'b0};
        vecs[7]  = '{8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'd1, 1'b0};
        vecs[8]  = '{8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'd0, 1'b0};
        vecs[9]  = '{8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'd0, 1'b0};
        vecs[10] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'd0, 1'b1};
        vecs[11] = '{8'hF7, 1'b0, 1'b1, 1'b0, 1'b1, !BYP, 4'h7, 4'd0, 1'b0};
        vecs[12] = '{8'hE5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'd0, 1'b0};
        vecs[13] = '{8'hE9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 4'd0, 1'b0};
        vecs[14] = '{8'hEA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 4'd0, 1'b1};
        vecs[15] = '{8'hD3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'd3, 1'b1};
        vecs[16] = '{8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'd2, 1'b1};

        reset_n     = 1'b0;
        pm_data     = 8'hE5;
        alu_zero    = 1'b0;
        alu_flag_we = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.ir", 32'(ir), 32'h00);
        check("rst.ir_valid", 32'(ir_valid), 32'd0);
        check("rst.loop_count", 32'(loop_count), 32'd0);
        check("rst.zero_flag", 32'(zero_flag), 32'd0);
        check_inactive("rst");

        // Release away from the clock edge; first cycle is still in FLUSH.
        reset_n = 1'b1;
        #1;
        check_inactive("startup0");
        check("startup0.ir_valid", 32'(ir_valid), 32'd0);
        @(posedge clk);
        #1;
        check("startup1.jump", 32'(jump), 32'd1);
        check("startup1.jaddr", 32'(jump_address), 32'h5);
        check("startup1.ir_valid", 32'(ir_valid), 32'd0);
        @(posedge clk);
        #1;
        check("startup2.ir", 32'(ir), 32'hE5);
        check("startup2.ir_valid", 32'(ir_valid), 32'd1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pm_data     = vecs[i].pm;
            alu_zero    = vecs[i].az;
            alu_flag_we = vecs[i].we;
            #1;
            check($sformatf("v%0d.jump", i), 32'(jump), 32'(vecs[i].j));
            check($sformatf("v%0d.cj", i), 32'(conditional_jump), 32'(vecs[i].cj));
            check($sformatf("v%0d.dont_jmp", i), 32'(dont_jmp), 32'(vecs[i].dj));
            check($sformatf("v%0d.jaddr", i), 32'(jump_address), 32'(vecs[i].ja));
            @(posedge clk);
            #1;
            check($sformatf("v%0d.ir", i), 32'(ir), 32'(vecs[i].pm));
            check($sformatf("v%0d.ir_valid", i), 32'(ir_valid), 32'd1);
            check($sformatf("v%0d.loop_count", i), 32'(loop_count), 32'(vecs[i].lc));
            check($sformatf("v%0d.zero_flag", i), 32'(zero_flag), 32'(vecs[i].zf));
        end

        // Asynchronous reset mid-loop (loop_count=2, ir=C2).
        @(negedge clk);
        pm_data     = 8'hC2;
        alu_flag_we = 1'b0;
        reset_n     = 1'b0;
        #1;
        check("midrst.ir", 32'(ir), 32'h00);
        check("midrst.ir_valid", 32'(ir_valid), 32'd0);
        check("midrst.loop_count", 32'(loop_count), 32'd0);
        check("midrst.zero_flag", 32'(zero_flag), 32'd0);
        check_inactive("midrst");
        @(negedge clk);
        pm_data = 8'hE5;
        reset_n = 1'b1;
        #1;
        check_inactive("rerelease0");
        @(posedge clk);
        #1;
        check("rerelease1.ir", 32'(ir), 32'h00);
        check("rerelease1.jump", 32'(jump), 32'd1);
        check("rerelease1.jaddr", 32'(jump_address), 32'h5);

        // LDC and DJNZ are frozen during FLUSH.
        @(negedge clk);
        reset_n = 1'b0;
        pm_data = 8'hD7;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("flushldc.loop_count", 32'(loop_count), 32'd0);
        @(posedge clk);
        #1;
        check("runldc.loop_count", 32'(loop_count), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
